// File: rtl/irq_ctrl_if.sv
// Data-bus interface between a bus master and the irq_ctrl register file.
// Latency: rdata is combinational from the slave registers; writes land on the clock edge.
// Backpressure: none; the slave accepts every selected access in the cycle it is presented.
// Ports: sel/we/addr/wdata driven by the master, rdata driven by the slave.
interface irq_ctrl_if;
   logic        sel;
   logic        we;
   logic [4:0]  addr;
   logic [31:0] wdata;
   logic [31:0] rdata;

   modport master (output sel, output we, output addr, output wdata, input rdata);
   modport slave  (input sel, input we, input addr, input wdata, output rdata);
endinterface

// File: rtl/irq_ctrl.sv
// Interrupt controller: latches edge/level IRQs into PEND, masks them onto CP0 HWInt.
// Latency: an IRQ sampled at edge k shows on hwint/irq_id right after edge k; reads are combinational.
// Backpressure: none; bus accesses always complete in one cycle, lost edges are counted instead.
// Ports: clk, reset (sync, active-high), irq_in[NUM_SRC], bus (slave modport), hwint[6], irq_id[3].
module irq_ctrl #(
   parameter int NUM_SRC = 6,
   parameter int CNT_W   = 16
) (
   input  logic               clk,
   input  logic               reset,
   input  logic [NUM_SRC-1:0] irq_in,
   irq_ctrl_if.slave          bus,
   output logic [5:0]         hwint,
   output logic [2:0]         irq_id
);

   // Register indices on addr[4:2].
   localparam logic [2:0] REG_PEND = 3'd0;
   localparam logic [2:0] REG_MASK = 3'd1;
   localparam logic [2:0] REG_MODE = 3'd2;
   localparam logic [2:0] REG_ACK  = 3'd3;
   localparam logic [2:0] REG_ID   = 3'd4;
   localparam logic [2:0] REG_LOST = 3'd5;

   logic [NUM_SRC-1:0] irq_q;
   logic [NUM_SRC-1:0] pend;
   logic [NUM_SRC-1:0] mask;
   logic [NUM_SRC-1:0] mode;
   logic [CNT_W-1:0]   lost_cnt;

   logic               bus_wr;
   logic [2:0]         reg_sel;
   logic               mask_wr;
   logic               mode_wr;
   logic               lost_wr;
   logic [NUM_SRC-1:0] ack_clr;
   logic [NUM_SRC-1:0] rise;
   logic [NUM_SRC-1:0] pend_nxt;
   logic [NUM_SRC-1:0] lost_vec;
   logic [5:0]         act;

   // Bits of the bus that no register consumes.
   logic unused_bus;
   assign unused_bus = ^{bus.addr[1:0], bus.wdata[31:NUM_SRC]};

   assign bus_wr  = bus.sel & bus.we;
   assign reg_sel = bus.addr[4:2];
   assign mask_wr = bus_wr && (reg_sel == REG_MASK);
   assign mode_wr = bus_wr && (reg_sel == REG_MODE);
   assign lost_wr = bus_wr && (reg_sel == REG_LOST);
   assign ack_clr = (bus_wr && (reg_sel == REG_ACK)) ? bus.wdata[NUM_SRC-1:0] : '0;

   // irq_q tracks the line in both modes, so switching a high line into
   // edge mode never fabricates a rising edge.
   assign rise = irq_in & ~irq_q;

   // Edge sources: a new rise beats a same-cycle ACK. Level sources simply
   // follow the line and ignore ACK.
   always_comb begin
      pend_nxt = '0;
      for (int i = 0; i < NUM_SRC; i++) begin
         if (mode[i])
            pend_nxt[i] = rise[i] | (pend[i] & ~ack_clr[i]);
         else
            pend_nxt[i] = irq_in[i];
      end
   end

   // An edge is lost only if it hits a bit that stays pending anyway; a rise
   // that coincides with its own ACK is the new request, not a lost one.
   assign lost_vec = mode & rise & pend & ~ack_clr;

   always_ff @(posedge clk) begin
      if (reset) begin
         irq_q    <= '0;
         pend     <= '0;
         mask     <= '0;
         mode     <= '0;
         lost_cnt <= '0;
      end else begin
         irq_q <= irq_in;
         pend  <= pend_nxt;
         if (mask_wr)
            mask <= bus.wdata[NUM_SRC-1:0];
         if (mode_wr)
            mode <= bus.wdata[NUM_SRC-1:0];
         // Clearing wins over this cycle's increment; one step per cycle no
         // matter how many sources lost an edge.
         if (lost_wr)
            lost_cnt <= '0;
         else if ((|lost_vec) && (lost_cnt != {CNT_W{1'b1}}))
            lost_cnt <= lost_cnt + 1'b1;
      end
   end

   always_comb begin
      act = '0;
      act[NUM_SRC-1:0] = pend & mask;
   end

   assign hwint = act;

   // Fixed priority, bit 0 highest: scan downwards so the lowest set bit is
   // the last one assigned.
   always_comb begin
      irq_id = 3'd7;
      for (int i = 5; i >= 0; i--) begin
         if (act[i])
            irq_id = 3'(i);
      end
   end

   always_comb begin
      bus.rdata = '0;
      case (reg_sel)
         REG_PEND: bus.rdata[NUM_SRC-1:0] = pend;
         REG_MASK: bus.rdata[NUM_SRC-1:0] = mask;
         REG_MODE: bus.rdata[NUM_SRC-1:0] = mode;
         REG_ID:   bus.rdata[2:0]         = irq_id;
         REG_LOST: bus.rdata[CNT_W-1:0]   = lost_cnt;
         default:  bus.rdata = '0;
      endcase
   end

endmodule

// File: doc/irq_ctrl.md
Name: irq_ctrl

Overview:
- Memory-mapped interrupt controller between peripheral IRQ lines and the CP0 HWInt[5:0] input.
- Latches device requests as either edge-triggered or level-sensitive, applies a per-source enable mask, and drives the masked pending vector to CP0.
- Software sees the block as registers on the data bus: a handler reads the top-priority source ID, services the device, then write-1-to-clears the pending bit.
- A saturating counter records lost edges (an edge that arrives while that source is already pending).

Parameters:
- NUM_SRC, 6, number of IRQ sources. Legal range 1..6. Unused HWInt bits are driven 0.
- CNT_W, 16, width of the lost-edge counter.

Ports:
- clk  input  1  system clock.
- reset  input  1  synchronous, active-high reset.
- irq_in  input  NUM_SRC  device request lines, synchronous to clk.
- sel  input  1  bus select for this block.
- we  input  1  bus write enable, qualified by sel.
- addr  input  5  byte offset. Only addr[4:2] is decoded.
- wdata  input  32  bus write data.
- rdata  output  32  bus read data, combinational from the registers.
- hwint  output  6  to CP0 HWInt. Equals {0, pend & mask}.
- irq_id  output  3  index of the lowest-numbered bit set in hwint. 7 when hwint is 0.

Behaviour:
- Register map, selected by addr[4:2]:
  - 0 PEND, read-only.
  - 1 MASK, read/write, 1 = enabled.
  - 2 MODE, read/write, 1 = edge-triggered, 0 = level-sensitive.
  - 3 ACK, write-only: write 1 to clear PEND bits. Reads return 0.
  - 4 ID, read-only: {29'b0, irq_id}.
  - 5 LOST, read returns {0, lost_cnt}. Any write clears it to 0.
  - 6 and 7 read 0 and ignore writes.
- Unused upper bits of every register read 0.
- Internal state:
  - irq_q: irq_in registered each cycle, for edge detection.
  - pend, mask, mode: NUM_SRC bits each.
  - lost_cnt: CNT_W bits.
- Reset (reset=1 at posedge): pend, mask, mode, irq_q and lost_cnt all go to 0. Outputs become hwint=0, irq_id=7, and rdata reflects the zero registers. Reset overrides any bus write in the same cycle.
- Per source i, evaluated at each posedge:
  - Edge mode (mode[i]=1):
    - rise = irq_in[i] & ~irq_q[i].
    - If rise: pend[i] <= 1. Set wins over an ACK to the same bit in the same cycle.
    - Else if ACK write with wdata[i]=1: pend[i] <= 0.
  - Level mode (mode[i]=0):
    - pend[i] <= irq_in[i].
    - ACK has no effect; the device must drop its line.
- Lost edges:
  - A lost edge is rise[i] & pend[i] & ~(ACK clearing bit i) in edge mode.
  - Each cycle lost_cnt increments by 1 if any source has a lost edge (not by the number of sources), saturating at all-ones.
  - A LOST write in the same cycle takes priority: clear to 0 and drop that cycle's increment.
- Latency:
  - irq_in rise sampled at edge k → pend set at edge k → hwint and irq_id valid in the cycle after edge k, with zero added combinational delay.
  - MASK, MODE and ACK writes take effect after the write edge.
- Mode switch: on a MODE write, pend keeps its current value and is updated under the new mode from the next edge. Writing MODE to 1 while the line is already high does not create an edge.
- Masking: a masked source still latches into pend and still counts lost edges. Unmasking a pending source asserts hwint the next cycle.
- Priority: irq_id is a fixed priority encoder, bit 0 highest.
- Bus writes with sel=0 or we=0 are ignored.
- Reads have no side effects.

Test Plan:
- Reset, then MODE=0x3F, MASK=0x3F; pulse irq_in[2] for one cycle → PEND=0x04, hwint=6'b000100 the cycle after the sampling edge, irq_id=2; write ACK=0x04 → PEND=0, hwint=0, irq_id=7.
- Edge mode on bit 0; hold irq_in[0] high for 5 cycles → only one pend set; ACK, then keep it high → no re-set; drop it and raise it again → pend set again.
- Level mode on bit 3 with MASK bit 3 = 0; raise irq_in[3] → PEND bit 3 = 1, hwint=0; write MASK=0x08 → hwint=0x08 next cycle; drop irq_in[3] → pend and hwint clear one edge later; an ACK write while the line is high changes nothing.
- Raise bits 1 and 4 together in edge mode with both unmasked → irq_id=1; ACK=0x02 → irq_id=4.
- Same cycle: a rise on bit 5 and ACK=0x20 → pend[5] stays 1, lost_cnt unchanged. Then three more edges on bit 5 without ACK → LOST=3; write LOST → 0. Preload near saturation (CNT_W=2, four lost edges) → counter holds at 3.
- Assert reset during a MASK write with irq_in active → all registers are 0 after the edge, hwint=0, irq_id=7.
